// File: rtl/cpu_core_mc_if.sv
// Instruction and data memory handshake bundle for cpu_core_mc.
// The core is the master on both channels; memory wrappers sit on the slave side.
interface cpu_core_mc_if #(
    parameter int DW = 8,
    parameter int AW = 6
);
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [15:0]   imem_rdata;

    logic          dmem_req;
    logic          dmem_we;
    logic [AW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata;
    logic          dmem_ack;
    logic [DW-1:0] dmem_rdata;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/cpu_core_mc.sv
// Parametrised multi-cycle core: IDLE/FETCH/EXEC/MEM/HALT sequencer with
// req/ack instruction and data memory channels that may stall it indefinitely.
module cpu_core_mc #(
    parameter int DW = 8,
    parameter int AW = 6,
    parameter int RN = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    cpu_core_mc_if.master     bus,
    output logic [AW-1:0]     pc_out,
    output logic              zf_out,
    output logic              halted
);
    localparam int RW = (RN > 1) ? $clog2(RN) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_t;

    state_t        state_reg;
    logic [AW-1:0] pc_reg;
    logic          zf_reg;
    logic [15:0]   ir_reg;
    logic          halted_reg;
    logic          imem_req_reg;
    logic          dmem_req_reg;
    logic          dmem_we_reg;
    logic [AW-1:0] dmem_addr_reg;
    logic [DW-1:0] dmem_wdata_reg;
    logic [DW-1:0] regs [RN];

    logic [3:0]    op;
    logic [RW-1:0] dst_idx;
    logic [RW-1:0] src0_idx;
    logic [RW-1:0] src1_idx;
    logic [7:0]    imm8;
    logic [DW-1:0] src0_val;
    logic [DW-1:0] src1_val;
    logic [DW-1:0] alu_res;
    logic          is_alu;
    logic [AW-1:0] pc_inc;
    logic [AW-1:0] jmp_tgt;
    logic          rf_we;
    logic [DW-1:0] rf_wdata;

    assign op       = ir_reg[15:12];
    assign dst_idx  = ir_reg[8 +: RW];
    assign src0_idx = ir_reg[4 +: RW];
    assign src1_idx = ir_reg[0 +: RW];
    assign imm8     = ir_reg[7:0];
    assign src0_val = regs[src0_idx];
    assign src1_val = regs[src1_idx];
    assign is_alu   = (op >= 4'h1) && (op <= 4'h7);
    assign pc_inc   = pc_reg + AW'(1);
    assign jmp_tgt  = imm8[AW-1:0];

    always_comb begin
        alu_res = '0;
        case (op)
            4'h1:    alu_res = src0_val + src1_val;
            4'h2:    alu_res = src0_val - src1_val;
            4'h3:    alu_res = src0_val & src1_val;
            4'h4:    alu_res = src0_val | src1_val;
            4'h5:    alu_res = src0_val ^ src1_val;
            4'h6:    alu_res = src0_val << 1;
            4'h7:    alu_res = src0_val >> 1;
            default: alu_res = '0;
        endcase
    end

    // Sources were read from the old register contents; the single write port
    // commits at the end of EXEC (ALU/LI) or on the data ack of a load.
    always_comb begin
        rf_we    = 1'b0;
        rf_wdata = alu_res;
        if (state_reg == S_EXEC && (is_alu || op == 4'h8)) begin
            rf_we    = 1'b1;
            rf_wdata = (op == 4'h8) ? DW'(imm8) : alu_res;
        end else if (state_reg == S_MEM && bus.dmem_ack && !dmem_we_reg) begin
            rf_we    = 1'b1;
            rf_wdata = bus.dmem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RN; i++) begin
                regs[i] <= '0;
            end
        end else if (rf_we) begin
            regs[dst_idx] <= rf_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            pc_reg         <= '0;
            zf_reg         <= 1'b0;
            ir_reg         <= '0;
            halted_reg     <= 1'b0;
            imem_req_reg   <= 1'b0;
            dmem_req_reg   <= 1'b0;
            dmem_we_reg    <= 1'b0;
            dmem_addr_reg  <= '0;
            dmem_wdata_reg <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    state_reg    <= S_FETCH;
                    imem_req_reg <= 1'b1;
                end
                S_FETCH: begin
                    if (bus.imem_ack) begin
                        ir_reg       <= bus.imem_rdata;
                        imem_req_reg <= 1'b0;
                        state_reg    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    state_reg    <= S_FETCH;
                    imem_req_reg <= 1'b1;
                    pc_reg       <= pc_inc;
                    if (is_alu) begin
                        zf_reg <= (alu_res == '0);
                    end
                    case (op)
                        4'hB: pc_reg <= jmp_tgt;
                        4'hC: if (zf_reg) pc_reg <= jmp_tgt;
                        4'hD: if (!zf_reg) pc_reg <= jmp_tgt;
                        4'h9, 4'hA: begin
                            state_reg      <= S_MEM;
                            imem_req_reg   <= 1'b0;
                            pc_reg         <= pc_reg;
                            dmem_req_reg   <= 1'b1;
                            dmem_we_reg    <= (op == 4'hA);
                            dmem_addr_reg  <= src1_val[AW-1:0];
                            dmem_wdata_reg <= src0_val;
                        end
                        4'hF: begin
                            state_reg    <= S_HALT;
                            imem_req_reg <= 1'b0;
                            halted_reg   <= 1'b1;
                            pc_reg       <= pc_reg;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    if (bus.dmem_ack) begin
                        dmem_req_reg <= 1'b0;
                        dmem_we_reg  <= 1'b0;
                        pc_reg       <= pc_inc;
                        state_reg    <= S_FETCH;
                        imem_req_reg <= 1'b1;
                    end
                end
                S_HALT: ;
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign bus.imem_req   = imem_req_reg;
    assign bus.imem_addr  = pc_reg;
    assign bus.dmem_req   = dmem_req_reg;
    assign bus.dmem_we    = dmem_we_reg;
    assign bus.dmem_addr  = dmem_addr_reg;
    assign bus.dmem_wdata = dmem_wdata_reg;
    assign pc_out         = pc_reg;
    assign zf_out         = zf_reg;
    assign halted         = halted_reg;
endmodule

// File: tb/tb_cpu_core_mc.sv
// Bench for cpu_core_mc: programs run against an instruction-level reference
// interpreter, with variable-latency memory responders and directed corner cases.
module tb_cpu_core_mc;
    localparam int DW = 16;
    localparam int AW = 6;
    localparam int RN = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cpu_core_mc_if #(.DW(DW), .AW(AW)) bus ();
    logic [AW-1:0] pc_out;
    logic          zf_out;
    logic          halted;

    cpu_core_mc #(.DW(DW), .AW(AW), .RN(RN)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .pc_out (pc_out),
        .zf_out (zf_out),
        .halted (halted)
    );

    int tests = 0;
    int fails = 0;

    logic [15:0] imem   [64];
    logic [15:0] dmem   [64];
    logic [15:0] m_dmem [64];
    int          dut_fetch_q[$];
    int          m_fetch_q[$];
    logic [31:0] dut_txn_q[$];
    logic [31:0] m_txn_q[$];

    int ilat_cfg, dlat_cfg, ilat_cur, dlat_cur, icnt, dcnt;
    bit spurious;
    bit prev_iwait, prev_dwait;
    logic [AW-1:0] prev_iaddr, prev_daddr;
    logic          prev_dwe;
    logic [DW-1:0] prev_dwdata;
    int   m_pc, m_cycles;
    logic m_zf;

    task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input int cfg);
        return (cfg < 0) ? int'($urandom_range(0, 3)) : cfg;
    endfunction

    // One clock of memory-side behaviour; entered and left at a falling edge.
    task automatic cycle();
        if (prev_iwait) begin
            check(32'(bus.imem_req), 32'd1, "imem_req_hold");
            check(32'(bus.imem_addr), 32'(prev_iaddr), "imem_addr_hold");
        end
        if (prev_dwait) begin
            check(32'(bus.dmem_req), 32'd1, "dmem_req_hold");
            check(32'(bus.dmem_addr), 32'(prev_daddr), "dmem_addr_hold");
            check(32'(bus.dmem_we), 32'(prev_dwe), "dmem_we_hold");
            check(32'(bus.dmem_wdata), 32'(prev_dwdata), "dmem_wdata_hold");
        end
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 16'($urandom);
        if (bus.imem_req) begin
            if (icnt >= ilat_cur) begin
                bus.imem_ack   = 1'b1;
                bus.imem_rdata = imem[bus.imem_addr];
                dut_fetch_q.push_back(int'(bus.imem_addr));
                icnt     = 0;
                ilat_cur = pick(ilat_cfg);
            end else begin
                icnt++;
            end
        end else if (spurious) begin
            bus.imem_ack = 1'($urandom);
        end
        prev_iwait = bus.imem_req && !bus.imem_ack;
        prev_iaddr = bus.imem_addr;

        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = 16'($urandom);
        if (bus.dmem_req) begin
            if (dcnt >= dlat_cur) begin
                bus.dmem_ack = 1'b1;
                if (bus.dmem_we) begin
                    dmem[bus.dmem_addr] = bus.dmem_wdata;
                    dut_txn_q.push_back({7'd0, 1'b1, 2'b00, bus.dmem_addr, bus.dmem_wdata});
                    $display("[TB] dmem store addr=%0d data=%0h", bus.dmem_addr, bus.dmem_wdata);
                end else begin
                    bus.dmem_rdata = dmem[bus.dmem_addr];
                    dut_txn_q.push_back({7'd0, 1'b0, 2'b00, bus.dmem_addr, 16'h0000});
                    $display("[TB] dmem load  addr=%0d data=%0h", bus.dmem_addr, bus.dmem_rdata);
                end
                dcnt     = 0;
                dlat_cur = pick(dlat_cfg);
            end else begin
                dcnt++;
            end
        end else if (spurious) begin
            bus.dmem_ack = 1'($urandom);
        end
        prev_dwait  = bus.dmem_req && !bus.dmem_ack;
        prev_daddr  = bus.dmem_addr;
        prev_dwe    = bus.dmem_we;
        prev_dwdata = bus.dmem_wdata;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check(32'(bus.imem_req), 32'd0, "rst_imem_req");
        check(32'(bus.imem_addr), 32'd0, "rst_imem_addr");
        check(32'(bus.dmem_req), 32'd0, "rst_dmem_req");
        check(32'(bus.dmem_we), 32'd0, "rst_dmem_we");
        check(32'(bus.dmem_addr), 32'd0, "rst_dmem_addr");
        check(32'(bus.dmem_wdata), 32'd0, "rst_dmem_wdata");
        check(32'(pc_out), 32'd0, "rst_pc");
        check(32'(zf_out), 32'd0, "rst_zf");
        check(32'(halted), 32'd0, "rst_halted");
        prev_iwait = 1'b0;
        prev_dwait = 1'b0;
        icnt       = 0;
        dcnt       = 0;
        ilat_cur   = pick(ilat_cfg);
        dlat_cur   = pick(dlat_cfg);
        rst_n      = 1'b1;
    endtask

    // Instruction-set interpreter; zero-wait cycle cost is 2 per instruction, 3 for LD/ST.
    task automatic model_run();
        logic [15:0] r [16];
        logic [15:0] ins, a, b, res;
        logic [3:0]  op, d;
        int pc;
        logic zf;
        bit done;
        foreach (r[i]) r[i] = 16'h0000;
        pc = 0; zf = 1'b0; done = 1'b0; m_cycles = 1;
        m_fetch_q.delete();
        m_txn_q.delete();
        for (int step = 0; step < 2000 && !done; step++) begin
            ins = imem[pc];
            m_fetch_q.push_back(pc);
            op = ins[15:12]; d = ins[11:8]; a = r[ins[7:4]]; b = r[ins[3:0]];
            m_cycles += 2;
            if (op >= 4'h1 && op <= 4'h7) begin
                case (op)
                    4'h1:    res = a + b;
                    4'h2:    res = a - b;
                    4'h3:    res = a & b;
                    4'h4:    res = a | b;
                    4'h5:    res = a ^ b;
                    4'h6:    res = a << 1;
                    default: res = a >> 1;
                endcase
                r[d] = res;
                zf = (res == 16'h0000);
                pc = (pc + 1) % 64;
            end else begin
                case (op)
                    4'h8: begin r[d] = {8'h00, ins[7:0]}; pc = (pc + 1) % 64; end
                    4'h9: begin
                        r[d] = m_dmem[b[5:0]];
                        m_txn_q.push_back({7'd0, 1'b0, 2'b00, b[5:0], 16'h0000});
                        m_cycles++;
                        pc = (pc + 1) % 64;
                    end
                    4'hA: begin
                        m_dmem[b[5:0]] = a;
                        m_txn_q.push_back({7'd0, 1'b1, 2'b00, b[5:0], a});
                        m_cycles++;
                        pc = (pc + 1) % 64;
                    end
                    4'hB: pc = int'(ins[5:0]);
                    4'hC: pc = zf ? int'(ins[5:0]) : (pc + 1) % 64;
                    4'hD: pc = !zf ? int'(ins[5:0]) : (pc + 1) % 64;
                    4'hF: done = 1'b1;
                    default: pc = (pc + 1) % 64;
                endcase
            end
        end
        m_pc = pc;
        m_zf = zf;
    endtask

    task automatic run_prog(input int il, input int dl, input bit spur, input bit chk_cyc,
                            input int probe_cyc, input int probe_pc, input int probe_zf,
                            input string name);
        int cyc;
        ilat_cfg = il; dlat_cfg = dl; spurious = spur;
        foreach (dmem[i]) dmem[i] = 16'($urandom);
        m_dmem = dmem;
        dut_fetch_q.delete();
        dut_txn_q.delete();
        model_run();
        do_reset();
        cyc = 0;
        while (halted !== 1'b1 && cyc < 4000) begin
            cycle();
            cyc++;
            if (cyc == probe_cyc) begin
                check(32'(pc_out), 32'(probe_pc), {name, "_probe_pc"});
                check(32'(zf_out), 32'(probe_zf), {name, "_probe_zf"});
            end
        end
        check(32'(halted), 32'd1, {name, "_halted"});
        if (chk_cyc) check(32'(cyc), 32'(m_cycles), {name, "_cycles"});
        check(32'(pc_out), 32'(m_pc), {name, "_final_pc"});
        check(32'(zf_out), 32'(m_zf), {name, "_final_zf"});
        check(32'(dut_fetch_q.size()), 32'(m_fetch_q.size()), {name, "_fetch_count"});
        for (int i = 0; i < m_fetch_q.size() && i < dut_fetch_q.size(); i++)
            check(32'(dut_fetch_q[i]), 32'(m_fetch_q[i]), {name, "_fetch_addr"});
        check(32'(dut_txn_q.size()), 32'(m_txn_q.size()), {name, "_txn_count"});
        for (int i = 0; i < m_txn_q.size() && i < dut_txn_q.size(); i++)
            check(dut_txn_q[i], m_txn_q[i], {name, "_txn"});
        $display("[TB] %s: %0d instructions, %0d data accesses, %0d cycles",
                 name, m_fetch_q.size(), m_txn_q.size(), cyc);
    endtask

    task automatic clear_imem();
        foreach (imem[i]) imem[i] = 16'hF000;
    endtask

    task automatic gen_random();
        int n, tgt;
        logic [3:0] op;
        clear_imem();
        n = $urandom_range(10, 40);
        for (int pc = 0; pc < n; pc++) begin
            op = 4'($urandom_range(0, 14));
            if (op >= 4'hB && op <= 4'hD) begin
                tgt = pc + 1 + $urandom_range(0, 3);
                if (tgt > n) tgt = n;
                imem[pc] = {op, 4'h0, 8'(tgt)};
            end else begin
                imem[pc] = {op, 4'($urandom_range(0, 14)), 8'($urandom)};
            end
        end
        for (int i = 0; i < 8; i++) begin
            imem[n + 2 * i]     = {4'h8, 4'hF, 8'(48 + i)};
            imem[n + 2 * i + 1] = {4'hA, 4'h0, 4'(i), 4'hF};
        end
    endtask

    initial begin
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 16'h0000;
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = 16'h0000;
        ilat_cfg = 0; dlat_cfg = 0; spurious = 1'b0;

        // LI r1,5; LI r2,5; SUB r3,r1,r2; JZ 7; then dump r3 to address 40.
        clear_imem();
        imem[0] = 16'h8105; imem[1] = 16'h8205; imem[2] = 16'h2312; imem[3] = 16'hC007;
        imem[7] = 16'h8F28; imem[8] = 16'hA03F;
        run_prog(0, 0, 1'b0, 1'b1, 9, 7, 1, "branch_zero_wait");
        run_prog(3, 0, 1'b0, 1'b0, -1, 0, 0, "branch_fetch_wait3");

        // Store then load through r4=9 with a two-cycle data memory; zf set beforehand.
        clear_imem();
        imem[0] = 16'h2777; imem[1] = 16'h8409; imem[2] = 16'h85A5; imem[3] = 16'hA054;
        imem[4] = 16'h9604; imem[5] = 16'h8F28; imem[6] = 16'hA06F;
        run_prog(0, 2, 1'b0, 1'b0, -1, 0, 0, "store_load");

        // pc wrap from 63 to 0, then 0xFFFF + 1 on 16-bit data.
        clear_imem();
        imem[0]  = 16'hD002; imem[1]  = 16'hB00A; imem[2]  = 16'hB03F; imem[63] = 16'h1111;
        imem[10] = 16'h8101; imem[11] = 16'h2201; imem[12] = 16'h1321;
        imem[13] = 16'h8F28; imem[14] = 16'hA02F; imem[15] = 16'h8F29; imem[16] = 16'hA03F;
        run_prog(0, 0, 1'b0, 1'b1, -1, 0, 0, "wrap_and_overflow");

        // HALT at pc=3 must stay quiet until reset.
        clear_imem();
        imem[0] = 16'h0000; imem[1] = 16'h0000; imem[2] = 16'h0000;
        run_prog(0, 0, 1'b0, 1'b1, -1, 0, 0, "halt");
        for (int i = 0; i < 20; i++) begin
            cycle();
            check(32'(bus.imem_req), 32'd0, "halt_no_imem_req");
            check(32'(bus.dmem_req), 32'd0, "halt_no_dmem_req");
            check(32'(halted), 32'd1, "halt_sticky");
            check(32'(pc_out), 32'd3, "halt_pc");
        end
        rst_n = 1'b0;
        #1;
        check(32'(halted), 32'd0, "halt_reset_halted");
        check(32'(pc_out), 32'd0, "halt_reset_pc");
        @(negedge clk);
        rst_n = 1'b1;

        // Reset during an unacknowledged load; r6 must still read back as 0.
        clear_imem();
        imem[0] = 16'h8409; imem[1] = 16'h9604;
        ilat_cfg = 0; dlat_cfg = 1000; spurious = 1'b0;
        do_reset();
        for (int i = 0; i < 20 && bus.dmem_req !== 1'b1; i++) cycle();
        check(32'(bus.dmem_req), 32'd1, "abort_ld_pending");
        cycle();
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        check(32'(bus.dmem_req), 32'd0, "abort_dmem_req_drop");
        check(32'(bus.imem_req), 32'd0, "abort_imem_req_drop");
        clear_imem();
        imem[0] = 16'h8F28; imem[1] = 16'hA06F;
        run_prog(0, 0, 1'b0, 1'b1, -1, 0, 0, "abort_restart");

        for (int t = 0; t < 6; t++) begin
            gen_random();
            if (t < 2) run_prog(0, 0, 1'b0, 1'b1, -1, 0, 0, "random_zero_wait");
            else       run_prog(-1, -1, 1'b1, 1'b0, -1, 0, 0, "random_stall");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cpu_core_mc.md
Name: cpu_core_mc

Overview:
- Parametrised multi-cycle successor to the single-cycle 8-bit core. Data width, PC width and register count are configurable.
- Instruction and data memories are external. Each is accessed through a req/ack handshake, so variable-latency memories can stall the core.
- A small FSM (IDLE/FETCH/EXEC/MEM/HALT) sequences each instruction. The block adds a HALT instruction and a JNZ branch.
- Sits between the system top and the imem/dmem wrappers; replaces the old pc/decoder/alu/zf/regfile cluster.

Parameters:
DW, 8, data/register width (8..32)
AW, 6, PC and data-address width (1..8)
RN, 16, number of registers (power of two, 2..16); register index uses low log2(RN) bits of field

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  instruction fetch request, held until imem_ack
imem_addr  out  AW  fetch address (= pc)
imem_ack  in  1  fetch complete; imem_rdata valid this cycle
imem_rdata  in  16  instruction word
dmem_req  out  1  data access request, held until dmem_ack
dmem_we  out  1  1 = store, 0 = load; stable while dmem_req
dmem_addr  out  AW  low AW bits of R[src1]
dmem_wdata  out  DW  R[src0] (store data)
dmem_ack  in  1  access complete; dmem_rdata valid this cycle for loads
dmem_rdata  in  DW  load data
pc_out  out  AW  current pc
zf_out  out  1  zero flag
halted  out  1  core in HALT state

Behaviour:
- Reset is asynchronous and active-low. Reset values: state=IDLE, pc=0, zf=0, all registers=0, IR=0. All outputs are 0.
- Asserting rst_n low mid-transaction drops req the same instant. No register or flag is written. No retry after release.
- Instruction fields: op=[15:12], dst=[11:8], src0=[7:4], src1=[3:0], imm8=[7:0]. imm8 is zero-extended to DW, or truncated to AW for jump targets.
- Opcodes:
  - 0 NOP
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR: R[dst]=R[src0] op R[src1]
  - 6 SHL, 7 SHR: R[dst]=R[src0] shifted by 1, zero fill
  - 8 LI: R[dst]=imm8
  - 9 LD: R[dst]=mem[R[src1]]
  - A ST: mem[R[src1]]=R[src0]
  - B JMP imm8
  - C JZ imm8 (taken if zf=1)
  - D JNZ imm8 (taken if zf=0)
  - E: NOP
  - F HALT
- Arithmetic is modulo 2^DW. zf is updated only by opcodes 1-7, set to (result==0). LI and LD leave zf unchanged.
- IDLE: one cycle after reset release, then FETCH.
- FETCH: imem_req=1, imem_addr=pc. On imem_ack, latch IR and go to EXEC. The request stays high while ack=0, for any number of cycles.
- EXEC: one cycle.
  - ALU/LI: write R[dst] and zf at the clock edge; pc+=1; go to FETCH.
  - JMP/taken branch: pc=imm8[AW-1:0]. Untaken branch: pc+=1.
  - LD/ST: go to MEM.
  - HALT: go to HALT, pc unchanged.
- MEM: dmem_req=1, dmem_we=(op==A); address and data are driven from registers, held stable.
  - On dmem_ack: an LD writes R[dst]=dmem_rdata; pc+=1; go to FETCH.
- HALT: absorbing state; halted=1; no requests issued. Only reset exits it.
- pc increment wraps modulo 2^AW (pc=2^AW-1 goes to 0).
- An ack while the matching req=0 is ignored.
- A source register equal to dst reads the old value; the write lands at the end of EXEC/MEM.
- Minimum latency with zero-wait memory (ack in the same cycle as req):
  - ALU/LI/branch: 2 cycles/instr
  - LD/ST: 3 cycles/instr
- Outputs are driven from state and registers only. No combinational path from ack to req.

Test Plan:
- Reset then imem ack same-cycle, program LI r1,5; LI r2,5; SUB r3,r1,r2; JZ 7 -> r3=0, zf=1, pc_out=7 after the 8th post-IDLE cycle.
- Fetch ack delayed 3 cycles on every instruction -> imem_req held high and imem_addr stable across waits; results identical to the zero-wait run.
- LI r4,9; LI r5,0xA5; ST r5,[r4]; LD r6,[r4] with 2-cycle dmem -> dmem_we=1 then 0, dmem_addr=9, dmem_wdata=0xA5, r6=0xA5, zf unchanged.
- AW=4, straight-line NOPs from pc=15 -> pc wraps to 0. DW=16, ADD 0xFFFF+1 -> 0, zf=1.
- HALT at pc=3 -> halted=1, pc_out=3, no imem_req for 20 cycles. Reset pulse -> halted=0, pc=0.
- Assert rst_n low while in MEM on an LD with ack pending -> dmem_req drops asynchronously, r[dst] stays 0, fetch restarts at pc=0.
